ram_event_capture: RTL



---
 rtl/ram_event_capture.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ram_event_capture.sv
// rtl/ram_event_capture.sv - glitch-filtered RAM bus event capture into a 2-entry queue
//
// Triple-samples the synchronized bus word and strobe, majority-votes each bit
// over the three samples, and on every rising edge of the voted strobe captures
// {voted bus word, cycle-delta timestamp} into a 2-entry FIFO.
//
// Ports:
//   clk            sole clock, rising edge
//   reset          asynchronous active-low reset
//   bus_in         bus word, already synchronized to clk
//   strobe_in      event strobe, active-high, already synchronized to clk
//   out_data       voted bus word of the queue head
//   out_ts         timestamp delta of the queue head
//   out_valid      queue non-empty
//   out_ready      consumer accepts the head when out_valid && out_ready
//   overflow       sticky: an event was dropped because the queue was full
//   overflow_clear synchronous clear of overflow (a coincident drop wins)
module ram_event_capture #(
  parameter int WIDTH    = 16,
  parameter int TS_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    bus_in,
  input  logic                strobe_in,
  output logic [WIDTH-1:0]    out_data,
  output logic [TS_WIDTH-1:0] out_ts,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overflow,
  input  logic                overflow_clear
);

  logic [WIDTH-1:0]    s0, s1, s2;
  logic                t0, t1, t2;
  logic                fs;
  logic [TS_WIDTH-1:0] ts_cnt;

  logic [WIDTH-1:0]    q_data [2];
  logic [TS_WIDTH-1:0] q_ts   [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;

  logic [WIDTH-1:0]    voted_bus;
  logic                voted_strobe;
  logic                evt;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;

  assign voted_bus    = (s0 & s1) | (s0 & s2) | (s1 & s2);
  assign voted_strobe = (t0 & t1) | (t0 & t2) | (t1 & t2);
  assign evt          = voted_strobe & ~fs;

  assign out_valid = (count != 2'd0);
  assign full      = (count == 2'd2);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot the new event needs.
  assign push      = evt & (~full | pop);
  assign drop      = evt & full & ~pop;

  assign out_data = q_data[rd_ptr];
  assign out_ts   = q_ts[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0       <= '0;
      s1       <= '0;
      s2       <= '0;
      t0       <= 1'b0;
      t1       <= 1'b0;
      t2       <= 1'b0;
      fs       <= 1'b0;
      ts_cnt   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_data[i] <= '0;
        q_ts[i]   <= '0;
      end
    end else begin
      s0 <= bus_in;
      s1 <= s0;
      s2 <= s1;
      t0 <= strobe_in;
      t1 <= t0;
      t2 <= t1;
      fs <= voted_strobe;

      // Restart at 1 so the next accepted event reports the edge distance;
      // dropped events leave the count running so deltas sum across a drop.
      if (push) begin
        ts_cnt <= TS_WIDTH'(1);
      end else if (ts_cnt != {TS_WIDTH{1'b1}}) begin
        ts_cnt <= ts_cnt + 1'b1;
      end

      if (push) begin
        q_data[wr_ptr] <= voted_bus;
        q_ts[wr_ptr]   <= ts_cnt;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
